// File: rtl/regfile_pkg.sv
// Shared encodings for the register-file sequencer: opcodes, mux selects,
// ALU functions and the controller state enum.
package regfile_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 3;
  localparam int ALU_TMO_DEF = 15;

  localparam logic [4:0] OP_NOP       = 5'b00000;
  localparam logic [4:0] OP_MOV_RN_R0 = 5'b00001;
  localparam logic [4:0] OP_MOV_R0_RN = 5'b00010;
  localparam logic [4:0] OP_MVI       = 5'b00011;
  localparam logic [4:0] OP_ALU_LO    = 5'b01000;
  localparam logic [4:0] OP_ALU_HI    = 5'b01100;

  localparam logic [1:0] MUX_RN_R0 = 2'b00;
  localparam logic [1:0] MUX_R0_RN = 2'b01;
  localparam logic [1:0] MUX_OR2   = 2'b10;
  localparam logic [1:0] MUX_ALU   = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_ISSUE,
    ST_WAIT,
    ST_WB
  } state_t;

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  endfunction

endpackage

// File: rtl/regfile_ctrl_tmo.sv
// WAIT-state timeout: down-counter loaded on clear, expired on its terminal
// count while enabled, i.e. in the ALU_TMO-th consecutive WAIT cycle.
module regfile_ctrl_tmo
  import regfile_pkg::*;
#(
  parameter int ALU_TMO = ALU_TMO_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(ALU_TMO + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CW'(ALU_TMO - 1);
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = enable && (cnt == '0);

endmodule

// File: rtl/regfile_ctrl.sv
// Initiator-side sequencer for the 8x8 dual-port register file: one
// instruction at a time, drives write/read controls and the ALU handshake.
//
// state | meaning
// IDLE  | ready for an instruction; NOP/illegal retire here
// WRITE | single register move/immediate write (we=1)
// READ  | read_seg=RN sampled by the file, operands valid next cycle
// ISSUE | alu_start pulse
// WAIT  | waiting for alu_done, bounded by the timeout counter
// WB    | ALU result written to R0 (we=1, mux_sel=11)
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ALU_TMO = ALU_TMO_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr,
  input  logic [DATA_W-1:0] imm,
  output logic              we,
  output logic [1:0]        mux_sel,
  output logic [ADDR_W-1:0] write_seg,
  output logic [ADDR_W-1:0] read_seg,
  output logic [DATA_W-1:0] or2,
  output logic [DATA_W-1:0] alu_wb,
  output logic              alu_start,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_done,
  output logic              done,
  output logic              err
);

  state_t            state_q, state_d;
  logic              instr_ready_d, we_d, alu_start_d, done_d, err_d;
  logic [1:0]        mux_sel_d;
  logic [ADDR_W-1:0] write_seg_d, read_seg_d;
  logic [DATA_W-1:0] or2_d, alu_wb_d;
  logic [2:0]        alu_op_d;
  logic [4:0]        opcode;
  logic [ADDR_W-1:0] rn;
  logic              accept, tmo_expired;

  assign opcode = instr[7:3];
  assign rn     = ADDR_W'(instr[2:0]);
  assign accept = instr_valid && instr_ready && (state_q == ST_IDLE);

  regfile_ctrl_tmo #(.ALU_TMO(ALU_TMO)) u_tmo (
    .clk     (clk),
    .clr     (clr),
    .clear   (state_q == ST_ISSUE),
    .enable  (state_q == ST_WAIT),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = 1'b0;
    alu_start_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mux_sel_d   = mux_sel;
    write_seg_d = write_seg;
    read_seg_d  = read_seg;
    or2_d       = or2;
    alu_wb_d    = alu_wb;
    alu_op_d    = alu_op;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_seg_d = rn;
          read_seg_d  = rn;
          case (opcode)
            OP_NOP: done_d = 1'b1;
            OP_MOV_RN_R0: begin
              state_d   = ST_WRITE;
              we_d      = 1'b1;
              mux_sel_d = MUX_RN_R0;
              done_d    = 1'b1;
            end
            OP_MOV_R0_RN: begin
              state_d   = ST_WRITE;
              we_d      = 1'b1;
              mux_sel_d = MUX_R0_RN;
              done_d    = 1'b1;
            end
            OP_MVI: begin
              state_d   = ST_WRITE;
              we_d      = 1'b1;
              mux_sel_d = MUX_OR2;
              or2_d     = imm;
              done_d    = 1'b1;
            end
            default: begin
              if (is_alu_op(opcode)) begin
                state_d  = ST_READ;
                alu_op_d = opcode[2:0];
              end else begin
                err_d = 1'b1;
              end
            end
          endcase
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ: begin
        state_d     = ST_ISSUE;
        alu_start_d = 1'b1;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // a result arriving in the last allowed cycle still wins over the timeout
        if (alu_done) begin
          state_d     = ST_WB;
          alu_wb_d    = alu_result;
          we_d        = 1'b1;
          mux_sel_d   = MUX_ALU;
          write_seg_d = '0;
          done_d      = 1'b1;
        end else if (tmo_expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    instr_ready_d = (state_d == ST_IDLE);
  end

  // instr_ready resets low and rises on the first edge after clr releases
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      instr_ready <= 1'b0;
      we          <= 1'b0;
      alu_start   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      mux_sel     <= '0;
      write_seg   <= '0;
      read_seg    <= '0;
      or2         <= '0;
      alu_wb      <= '0;
      alu_op      <= '0;
    end else begin
      state_q     <= state_d;
      instr_ready <= instr_ready_d;
      we          <= we_d;
      alu_start   <= alu_start_d;
      done        <= done_d;
      err         <= err_d;
      mux_sel     <= mux_sel_d;
      write_seg   <= write_seg_d;
      read_seg    <= read_seg_d;
      or2         <= or2_d;
      alu_wb      <= alu_wb_d;
      alu_op      <= alu_op_d;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: register-file and ALU environment models, an
// architectural register model and a per-cycle schedule of expected outputs.
module tb_regfile_ctrl;
  import regfile_pkg::*;

  localparam int TMO = 15;
  localparam int N   = 1024;

  logic       clk = 1'b0;
  logic       clr, instr_valid, instr_ready;
  logic [7:0] instr, imm;
  logic       we, alu_start, alu_done, done, err;
  logic [1:0] mux_sel;
  logic [2:0] write_seg, read_seg, alu_op;
  logic [7:0] or2, alu_wb, alu_result;

  regfile_ctrl #(.DATA_W(8), .ADDR_W(3), .ALU_TMO(TMO)) dut (
    .clk(clk), .clr(clr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .imm(imm), .we(we), .mux_sel(mux_sel), .write_seg(write_seg),
    .read_seg(read_seg), .or2(or2), .alu_wb(alu_wb), .alu_start(alu_start),
    .alu_op(alu_op), .alu_result(alu_result), .alu_done(alu_done),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_on  = 0;
  int alu_delay = 0;
  int last_c0 = 0;
  logic [7:0] alu_b_seen = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // register file environment: registered reads, write per mux_sel
  logic [7:0] regs [8];
  logic [7:0] arch [8];
  logic [7:0] dout_a, dout_b;
  initial begin
    for (int i = 0; i < 8; i++) begin regs[i] = 8'h00; arch[i] = 8'h00; end
  end
  always @(posedge clk) begin
    if (we) begin
      case (mux_sel)
        2'b00: regs[write_seg] <= regs[0];
        2'b01: regs[0] <= regs[write_seg];
        2'b10: regs[write_seg] <= or2;
        default: regs[write_seg] <= alu_wb;
      endcase
    end
    dout_a <= regs[0];
    dout_b <= regs[read_seg];
  end

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // ALU: answers alu_delay cycles after the start pulse; delay 0 never answers
  initial begin
    logic [7:0] a, b;
    logic [2:0] op;
    alu_done = 1'b0;
    alu_result = 8'h00;
    forever begin
      @(negedge clk);
      if (alu_start === 1'b1 && alu_delay > 0) begin
        a = dout_a; b = dout_b; op = alu_op; alu_b_seen = dout_b;
        repeat (alu_delay) @(negedge clk);
        alu_result = alu_fn(op, a, b);
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
      end
    end
  end

  bit         e_we[N], e_done[N], e_err[N], e_start[N], e_busy[N];
  bit         f_or2[N], f_wb[N], f_rs[N], f_op[N];
  logic [1:0] e_mux[N];
  logic [2:0] e_seg[N], e_rs[N], e_op[N];
  logic [7:0] e_or2[N], e_wb[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < N; i++) begin
      e_we[i] = 0; e_done[i] = 0; e_err[i] = 0; e_start[i] = 0; e_busy[i] = 0;
      f_or2[i] = 0; f_wb[i] = 0; f_rs[i] = 0; f_op[i] = 0;
    end
  endtask

  // expected timeline from the accept cycle c0, plus architectural effect
  task automatic schedule(input logic [7:0] ins, input logic [7:0] im, input int d, input int c0);
    logic [4:0] op;
    logic [2:0] rn;
    logic [7:0] res;
    int e;
    op = ins[7:3];
    rn = ins[2:0];
    f_rs[c0+1] = 1; e_rs[c0+1] = rn;
    if (op == 5'b00000) begin
      e_done[c0+1] = 1;
    end else if (op >= 5'b00001 && op <= 5'b00011) begin
      e_we[c0+1] = 1; e_done[c0+1] = 1; e_busy[c0+1] = 1; e_seg[c0+1] = rn;
      e_mux[c0+1] = op[1:0] - 2'd1;
      if (op == 5'b00011) begin
        f_or2[c0+1] = 1; e_or2[c0+1] = im; arch[rn] = im;
      end else if (op == 5'b00001) arch[rn] = arch[0];
      else arch[0] = arch[rn];
    end else if (op >= 5'b01000 && op <= 5'b01100) begin
      e_start[c0+2] = 1;
      if (d >= 1 && d <= TMO) begin
        e = c0 + 3 + d;
        res = alu_fn(op[2:0], arch[0], arch[rn]);
        arch[0] = res;
        e_we[e] = 1; e_done[e] = 1; e_mux[e] = 2'b11; e_seg[e] = 3'd0;
        f_wb[e] = 1; e_wb[e] = res;
      end else begin
        e = c0 + 3 + TMO;
        e_err[e] = 1;
        e = e - 1;
      end
      for (int i = c0 + 1; i <= e; i++) begin
        e_busy[i] = 1; f_op[i] = 1; e_op[i] = op[2:0];
      end
    end else begin
      e_err[c0+1] = 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && !clr && cyc < N) begin
      check("we", we, e_we[cyc]);
      check("done", done, e_done[cyc]);
      check("err", err, e_err[cyc]);
      check("alu_start", alu_start, e_start[cyc]);
      check("instr_ready", instr_ready, !e_busy[cyc]);
      check("we_err_excl", we & err, 0);
      if (e_we[cyc]) begin
        check("mux_sel", mux_sel, e_mux[cyc]);
        check("write_seg", write_seg, e_seg[cyc]);
      end
      if (f_or2[cyc]) check("or2", or2, e_or2[cyc]);
      if (f_wb[cyc])  check("alu_wb", alu_wb, e_wb[cyc]);
      if (f_rs[cyc])  check("read_seg", read_seg, e_rs[cyc]);
      if (f_op[cyc])  check("alu_op", alu_op, e_op[cyc]);
    end
  end

  task automatic issue(input logic [7:0] ins, input logic [7:0] im, input int d);
    bit got = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (instr_ready === 1'b1) begin got = 1; break; end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL issue_wait: instr_ready never rose for instr %0h", ins);
      return;
    end
    last_c0 = cyc;
    alu_delay = d;
    instr = ins; imm = im; instr_valid = 1'b1;
    schedule(ins, im, d, cyc);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic settle_and_compare();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_ready === 1'b1) break;
    end
    repeat (2) @(negedge clk);
    for (int r = 0; r < 8; r++) check($sformatf("reg%0d", r), regs[r], arch[r]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, we, 0);
    check({tag, "_ready"}, instr_ready, 0);
    check({tag, "_start"}, alu_start, 0);
    check({tag, "_done_err"}, {done, err}, 0);
    check({tag, "_segs_mux"}, {mux_sel, write_seg, read_seg, alu_op}, 0);
    check({tag, "_data"}, {or2, alu_wb}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; instr_valid = 1'b0; instr = 8'h00; imm = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    clr = 1'b0;
    @(negedge clk);
    check("ready_after_rst", instr_ready, 1);
    chk_on = 1;

    issue(8'h1B, 8'h5A, 0);             // MVI R3,0x5A
    settle_and_compare();
    check("R3_lit", regs[3], 8'h5A);
    issue(8'h13, 8'h00, 0);             // MOV R0,R3
    issue(8'h0D, 8'h00, 0);             // MOV R5,R0
    settle_and_compare();
    check("R5_lit", regs[5], 8'h5A);

    issue(8'h18, 8'h10, 0);             // MVI R0,0x10
    issue(8'h1B, 8'h22, 0);             // MVI R3,0x22
    issue(8'h43, 8'h00, 2);             // ADD R3
    instr = 8'h1F; imm = 8'hEE; instr_valid = 1'b1;  // held while busy
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_ready === 1'b1) break;
    end
    instr_valid = 1'b0;
    settle_and_compare();
    check("dataout_B_lit", alu_b_seen, 8'h22);
    check("R0_add_lit", regs[0], 8'h32);
    check("R7_untouched", regs[7], 8'h00);

    issue(8'hFF, 8'h00, 0);             // illegal 11111
    issue(8'h00, 8'h00, 0);             // NOP
    issue(8'h68, 8'h00, 0);             // illegal 01101
    issue(8'h20, 8'h00, 0);             // illegal 00100
    issue(8'h08, 8'h00, 0);             // MOV R0,R0 self-copy
    issue(8'h4D, 8'h00, 1);             // SUB R5
    issue(8'h53, 8'h00, 3);             // AND R3
    issue(8'h5D, 8'h00, 1);             // OR R5
    issue(8'h63, 8'h00, TMO);           // XOR R3, done in last WAIT cycle
    settle_and_compare();
    check("R0_xor_lit", regs[0], 8'h78);

    issue(8'h43, 8'h00, 0);             // ADD R3, ALU silent
    for (int i = 0; i < 40; i++) begin
      if (err === 1'b1) break;
      @(negedge clk);
    end
    check("tmo_latency", cyc - last_c0, 3 + TMO);
    issue(8'h19, 8'h77, 0);             // MVI R1,0x77
    settle_and_compare();
    check("R1_lit", regs[1], 8'h77);

    issue(8'h45, 8'h00, 0);             // ADD R5, aborted by clr in WAIT
    repeat (3) @(negedge clk);
    #2;
    chk_on = 0;
    clr = 1'b1;
    #1;
    check_all_zero("clr_mid");
    clear_from(cyc);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("ready_after_clr", instr_ready, 1);
    chk_on = 1;
    repeat (25) @(negedge clk);
    settle_and_compare();

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
Initiator-side sequencer for the 8x8 dual-port register file. It accepts one register-transfer instruction at a time over a valid/ready handshake and decodes it. It then drives the register file's we / mux_sel / write_seg / read_seg / OR2 / ALU_IN inputs with correct cycle timing, including the file's one-cycle registered read latency. For ALU instructions it launches the ALU on R0 (dataout_A) and RN (dataout_B), then writes the result back to R0.

Parameters:
DATA_W, 8, register and operand width
ADDR_W, 3, register index width (8 registers)
ALU_TMO, 15, max cycles waited for alu_done before aborting

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-high reset
instr_valid  input  1  instruction present
instr_ready  output  1  controller idle, instruction accepted when valid&ready
instr  input  8  [7:3] opcode, [2:0] RN index
imm  input  DATA_W  immediate for MVI
we  output  1  register file write enable
mux_sel  output  2  00 RN<-R0, 01 R0<-RN, 10 RN<-OR2, 11 R0/RN<-ALU_IN
write_seg  output  ADDR_W  register file write index
read_seg  output  ADDR_W  register file read index (B port)
or2  output  DATA_W  immediate to register file OR2
alu_wb  output  DATA_W  latched ALU result to register file ALU_IN
alu_start  output  1  one-cycle ALU launch pulse
alu_op  output  3  ALU function: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
alu_result  input  DATA_W  ALU result
alu_done  input  1  ALU result valid
done  output  1  one-cycle pulse on instruction retire
err  output  1  one-cycle pulse on illegal opcode or ALU timeout

Behaviour:
- All outputs registered. On clr, asynchronously: state=IDLE; we, alu_start, done, err = 0; mux_sel, write_seg, read_seg, alu_op = 0; or2, alu_wb = 0; instr_ready = 1 once clr deasserts.
- Opcodes:
  - 00000 NOP
  - 00001 MOV RN,R0
  - 00010 MOV R0,RN
  - 00011 MVI RN,imm
  - 01000–01100 ALU ADD/SUB/AND/OR/XOR with alu_op = opcode[2:0]
  - anything else is illegal.
- FSM states: IDLE, WRITE, READ, ISSUE, WAIT, WB.
- IDLE, instr_ready=1. On accept (cycle 0):
  - Latch RN. Drive write_seg=RN and read_seg=RN from cycle 1. Latch or2=imm for MVI.
  - MOV/MVI -> WRITE. ALU -> READ.
  - NOP -> IDLE, with done=1 in cycle 1.
  - Illegal -> IDLE, with err=1 in cycle 1 and no write.
- WRITE (cycle 1): we=1 for exactly one cycle, mux_sel 00/01/10 per opcode, done=1, then IDLE.
  - MOV R0,RN drives write_seg=RN, which acts as the source index.
  - instr_ready returns high in cycle 2.
- READ (cycle 1): read_seg=RN is sampled by the register file. dataout_A/B are valid from cycle 2.
- ISSUE (cycle 2): alu_start=1 for exactly one cycle, with alu_op stable from cycle 1 until retire. Next state WAIT.
- WAIT: alu_done is ignored during ISSUE and sampled only in WAIT.
  - On alu_done=1: alu_wb<=alu_result, go to WB.
  - The cycle counter starts at 0 on entry. If it reaches ALU_TMO without alu_done: err=1, no write, IDLE.
- WB: we=1, mux_sel=11, write_seg=0 (R0), done=1, then IDLE.
  - Minimum ALU latency (alu_done in the first WAIT cycle) is accept cycle 0, WB in cycle 4, ready in cycle 5.
- instr_ready=0 in every state except IDLE. instr_valid while busy is ignored; the instruction is not latched.
- we is never high outside WRITE/WB. we and err are never high in the same cycle.
- clr mid-operation: the current instruction is abandoned with no write issued. we and alu_start drop immediately; done and err are not pulsed.
- RN=0 is legal for all forms. MOV RN,R0 with RN=0 still issues the write (self-copy).

Decomposition:
- Shared package regfile_pkg holds:
  - opcode constants
  - mux_sel encodings (MUX_RN_R0, MUX_R0_RN, MUX_OR2, MUX_ALU)
  - alu_op encodings
  - FSM state enum
  - DATA_W/ADDR_W defaults
- One natural sub-module: regfile_ctrl_tmo. It is the WAIT-state timeout counter, with inputs clear/enable and output expired.

Test Plan:
- Reset then MVI R3,0x5A: accepted cycle 0 -> cycle 1 we=1, mux_sel=10, write_seg=3, or2=0x5A, done=1; instr_ready=1 cycle 2; R3 reads 0x5A.
- MOV R0,R3 then MOV R5,R0: the first gives mux_sel=01, write_seg=3; the second gives mux_sel=00, write_seg=5. R5 reads 0x5A and instr_ready drops for exactly one cycle each.
- ADD R3 with R0=0x10, R3=0x22, ALU model done two cycles after start with 0x32: alu_start in cycle 2 with alu_op=000, dataout_B=0x22 in cycle 2; WB we=1, mux_sel=11, write_seg=0, alu_wb=0x32; R0=0x32.
- Illegal opcode 11111 and NOP: err=1 (or done=1 for NOP) in cycle 1, we never asserts, and instr_valid held during busy cycles of a prior ADD is not accepted.
- ALU never asserts done: err=1 after ALU_TMO WAIT cycles, no write, and the next MVI is accepted normally.
- clr asserted in WAIT mid-ADD: all outputs go to 0 asynchronously, there is no WB and no done, and instr_ready=1 after release.
